// File: rtl/cpstr_pkg.sv
// Constants and state encoding shared by the control-port escaper and unescaper.
package cpstr_pkg;
  localparam logic [7:0] ESC_CHAR_DEF = 8'd27;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;
endpackage

// File: rtl/cpstr_obuf.sv
// One-entry ready/valid register stage. An entry that drains and loads in the
// same cycle stays full and takes the new byte, which keeps one byte per cycle.
module cpstr_obuf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       free
);
  logic       full_q, full_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    free   = !full_q || out_ready;
    full_d = full_q && !out_ready;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= 8'd0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = full_q;
endmodule

// File: rtl/cpstr_unesc.sv
// Control-port stream unescaper: doubled ESC_CHAR goes to main as one byte,
// the byte after a lone ESC_CHAR goes to the esc stream.
module cpstr_unesc
  import cpstr_pkg::*;
#(
  parameter logic [7:0] ESC_CHAR = ESC_CHAR_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_esc_data,
  output logic       o_esc_valid,
  input  logic       i_esc_ready,
  output logic       o_esc_pending
);
  state_e state_q, state_d;
  logic   is_esc, main_free, esc_free, main_load, esc_load;

  assign is_esc = (i_data == ESC_CHAR);

  // o_ready is a function of byte, state and downstream space only; i_valid
  // merely qualifies the accept.
  always_comb begin
    state_d   = state_q;
    o_ready   = 1'b0;
    main_load = 1'b0;
    esc_load  = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (is_esc) begin
          o_ready = 1'b1;
          if (i_valid) state_d = ST_PENDING;
        end else begin
          o_ready   = main_free;
          main_load = i_valid && main_free;
        end
      end
      default: begin
        if (is_esc) begin
          o_ready   = main_free;
          main_load = i_valid && main_free;
          if (main_load) state_d = ST_NORMAL;
        end else begin
          o_ready  = esc_free;
          esc_load = i_valid && esc_free;
          if (esc_load) state_d = ST_NORMAL;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_NORMAL;
    else          state_q <= state_d;
  end

  assign o_esc_pending = (state_q == ST_PENDING);

  cpstr_obuf u_main (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (main_load),
    .load_data (i_data),
    .out_data  (o_data),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .free      (main_free)
  );

  cpstr_obuf u_esc (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (esc_load),
    .load_data (i_data),
    .out_data  (o_esc_data),
    .out_valid (o_esc_valid),
    .out_ready (i_esc_ready),
    .free      (esc_free)
  );
endmodule

// File: tb/tb_cpstr_unesc.sv
// Directed bench for cpstr_unesc: hand-computed expectations per cycle.
module tb_cpstr_unesc;
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_esc_data;
  logic       o_esc_valid;
  logic       i_esc_ready;
  logic       o_esc_pending;

  int checks = 0;
  int errors = 0;

  cpstr_unesc dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_esc_data    (o_esc_data),
    .o_esc_valid   (o_esc_valid),
    .i_esc_ready   (i_esc_ready),
    .o_esc_pending (o_esc_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // present a byte and let combinational o_ready settle
  task automatic put(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_data = 8'h00; i_valid = 1'b0;
    i_ready = 1'b1; i_esc_ready = 1'b1;
    #12;
    chk("rst_o_valid", {7'd0, o_valid}, 8'h00);
    chk("rst_o_data", o_data, 8'h00);
    chk("rst_esc_valid", {7'd0, o_esc_valid}, 8'h00);
    chk("rst_esc_data", o_esc_data, 8'h00);
    chk("rst_pending", {7'd0, o_esc_pending}, 8'h00);
    i_rst_n = 1'b1;
    tick();

    // plain bytes back to back
    put(8'h41); chk("p_rdy41", {7'd0, o_ready}, 8'h01);
    tick(); chk("p_v41", {7'd0, o_valid}, 8'h01); chk("p_d41", o_data, 8'h41);
    put(8'h42); tick(); chk("p_v42", {7'd0, o_valid}, 8'h01); chk("p_d42", o_data, 8'h42);
    put(8'h43); tick(); chk("p_d43", o_data, 8'h43); chk("p_esc43", {7'd0, o_esc_valid}, 8'h00);
    i_valid = 1'b0; tick(); chk("p_idle", {7'd0, o_valid}, 8'h00);

    // ESC ESC -> single 1B on main
    put(8'h1B); tick();
    chk("ee_pend", {7'd0, o_esc_pending}, 8'h01); chk("ee_v0", {7'd0, o_valid}, 8'h00);
    put(8'h1B); chk("ee_rdy", {7'd0, o_ready}, 8'h01); tick();
    chk("ee_v", {7'd0, o_valid}, 8'h01); chk("ee_d", o_data, 8'h1B);
    chk("ee_pend0", {7'd0, o_esc_pending}, 8'h00); chk("ee_esc", {7'd0, o_esc_valid}, 8'h00);
    i_valid = 1'b0; tick(); chk("ee_idle", {7'd0, o_valid}, 8'h00);

    // ESC 05 -> esc stream
    put(8'h1B); tick();
    put(8'h05); tick();
    chk("e5_ev", {7'd0, o_esc_valid}, 8'h01); chk("e5_ed", o_esc_data, 8'h05);
    chk("e5_mv", {7'd0, o_valid}, 8'h00);
    i_valid = 1'b0; tick(); chk("e5_idle", {7'd0, o_esc_valid}, 8'h00);

    // mixed 41 1B 1B 1B 07 42
    put(8'h41); tick(); chk("m_d41", o_data, 8'h41);
    put(8'h1B); tick(); chk("m_v1", {7'd0, o_valid}, 8'h00); chk("m_p1", {7'd0, o_esc_pending}, 8'h01);
    put(8'h1B); tick(); chk("m_v2", {7'd0, o_valid}, 8'h01); chk("m_d1b", o_data, 8'h1B);
    put(8'h1B); tick(); chk("m_v3", {7'd0, o_valid}, 8'h00); chk("m_p3", {7'd0, o_esc_pending}, 8'h01);
    put(8'h07); tick(); chk("m_ev", {7'd0, o_esc_valid}, 8'h01); chk("m_ed", o_esc_data, 8'h07);
    put(8'h42); tick(); chk("m_d42", o_data, 8'h42); chk("m_ev0", {7'd0, o_esc_valid}, 8'h00);
    i_valid = 1'b0; tick();

    // backpressure on main
    i_ready = 1'b0;
    put(8'h43); tick(); chk("b_v43", {7'd0, o_valid}, 8'h01); chk("b_d43", o_data, 8'h43);
    put(8'h44); chk("b_rdy44", {7'd0, o_ready}, 8'h00);
    tick(); chk("b_hold", o_data, 8'h43); chk("b_pend0", {7'd0, o_esc_pending}, 8'h00);
    put(8'h1B); chk("b_rdy1b", {7'd0, o_ready}, 8'h01);
    tick(); chk("b_pend", {7'd0, o_esc_pending}, 8'h01);
    put(8'h1B); chk("b_rdyee", {7'd0, o_ready}, 8'h00);
    put(8'h09); chk("b_rdy09", {7'd0, o_ready}, 8'h01);
    tick();
    chk("b_ev", {7'd0, o_esc_valid}, 8'h01); chk("b_ed", o_esc_data, 8'h09);
    chk("b_mv", {7'd0, o_valid}, 8'h01); chk("b_md", o_data, 8'h43);
    chk("b_pend2", {7'd0, o_esc_pending}, 8'h00);
    i_valid = 1'b0; tick();
    chk("b_ev0", {7'd0, o_esc_valid}, 8'h00); chk("b_mv1", {7'd0, o_valid}, 8'h01);
    i_ready = 1'b1; tick(); chk("b_drain", {7'd0, o_valid}, 8'h00);

    // esc stream stalled blocks a second esc follower
    i_esc_ready = 1'b0;
    put(8'h1B); tick(); put(8'h06); tick();
    chk("s_ev", {7'd0, o_esc_valid}, 8'h01);
    put(8'h1B); tick(); put(8'h08); chk("s_rdy", {7'd0, o_ready}, 8'h00);
    tick(); chk("s_hold", o_esc_data, 8'h06); chk("s_pend", {7'd0, o_esc_pending}, 8'h01);
    i_esc_ready = 1'b1; #1; chk("s_rdy1", {7'd0, o_ready}, 8'h01);
    tick(); chk("s_ed8", o_esc_data, 8'h08);
    i_valid = 1'b0; tick();

    // reset mid-operation
    i_ready = 1'b0;
    put(8'h41); tick(); put(8'h1B); tick();
    i_valid = 1'b0;
    chk("r_pre", {7'd0, o_esc_pending}, 8'h01);
    #2 i_rst_n = 1'b0; #1;
    chk("r_v", {7'd0, o_valid}, 8'h00); chk("r_d", o_data, 8'h00);
    chk("r_ev", {7'd0, o_esc_valid}, 8'h00); chk("r_pend", {7'd0, o_esc_pending}, 8'h00);
    tick(); i_rst_n = 1'b1; i_ready = 1'b1; tick();
    put(8'h05); tick();
    chk("r_mv", {7'd0, o_valid}, 8'h01); chk("r_md", o_data, 8'h05);
    chk("r_ev2", {7'd0, o_esc_valid}, 8'h00);
    i_valid = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
